rr_grant_arbiter_8: RTL and testbench

Round-robin arbiter that shares one resource among eight requesters and drives a registered one-hot grant plus its 3-bit binary index. It replaces ad-hoc priority logic wherever one resource, such as an encoder-fed datapath or a bus port, is shared. A grant is held while its owner keeps requesting. An optional hold limit forces re-arbitration so that no requester starves.

---
 rtl/arb_pkg.sv | 36 +++
 rtl/grant_index_encoder.sv | 16 +
 rtl/rr_grant_arbiter_8.sv | 96 +++++++++
 tb/tb_rr_grant_arbiter_8.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types, widths and the rotating-priority search for the round-robin arbiter.
package arb_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned HOLD_W  = 8;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Rotate the mask down by start, take the lowest set bit, rotate the index back.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] mask,
                                      input logic [IDX_W-1:0]   start);
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        pick_t                p;
        dbl = {mask, mask} >> start;
        rot = dbl[NUM_REQ-1:0];
        p   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                p.found = 1'b1;
                p.idx   = start + IDX_W'(j);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/grant_index_encoder.sv
// One-hot to binary encoder for the grant vector; a zero input encodes to 0.
module grant_index_encoder
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (onehot[i]) idx = idx | IDX_W'(i);
        end
    end

endmodule

// File: rtl/rr_grant_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant, held while the owner
// keeps requesting, and an optional hold limit that forces re-arbitration under contention.
module rr_grant_arbiter_8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HoldMax  = '1;

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] others;
    logic [IDX_W-1:0]   cur_idx;
    logic               hand_off;
    pick_t              pick;

    grant_index_encoder u_enc (
        .onehot (gnt_q),
        .idx    (cur_idx)
    );

    // Owner is masked out: in IDLE gnt_q is zero, and on release the owner bit is already low,
    // so one search serves initial grant, handoff and forced preemption alike.
    assign others = req & ~gnt_q;
    assign pick   = rr_pick(others, ptr_q);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        gnt_d    = gnt_q;
        hand_off = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick.found) hand_off = 1'b1;
            end
            ARB_GRANT: begin
                if (req[cur_idx]) begin
                    // >= so a counter that ran past the limit uncontended still yields at once
                    if (MAX_HOLD != 0 && hold_q >= HoldLast && pick.found) begin
                        hand_off = 1'b1;
                    end else if (hold_q != HoldMax) begin
                        hold_d = hold_q + 8'd1;
                    end
                end else if (pick.found) begin
                    hand_off = 1'b1;
                end else begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase
        if (hand_off) begin
            state_d = ARB_GRANT;
            gnt_d   = NUM_REQ'(1) << pick.idx;
            ptr_d   = pick.idx + 3'd1;
            hold_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = cur_idx;
    assign gnt_vld = |gnt_q;

endmodule

// File: tb/tb_rr_grant_arbiter_8.sv
// Directed bench: two arbiters (MAX_HOLD = 0 and 4) share req/rst and are checked step by step.
module tb_rr_grant_arbiter_8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt0, gnt4;
    logic [2:0] idx0, idx4;
    logic       vld0, vld4;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_grant_arbiter_8 #(.MAX_HOLD(0)) u0 (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt0),
        .gnt_idx (idx0),
        .gnt_vld (vld0)
    );

    rr_grant_arbiter_8 #(.MAX_HOLD(4)) u4 (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt4),
        .gnt_idx (idx4),
        .gnt_vld (vld4)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [2:0] exp_idx;
        rst = 1'b1;
        req = 8'h00;
        step();
        step();
        check("reset_gnt", gnt0, 8'h00);
        check("reset_idx", {5'd0, idx0}, 8'h00);
        check("reset_vld", {7'd0, vld0}, 8'h00);

        // mid-grant asynchronous reset
        rst = 1'b0;
        req = 8'hFF;
        step();
        check("first_gnt", gnt0, 8'h01);
        check("first_idx", {5'd0, idx0}, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_gnt", gnt0, 8'h00);
        check("async_rst_vld", {7'd0, vld0}, 8'h00);
        check("async_rst_idx", {5'd0, idx0}, 8'h00);
        req = 8'h00;
        step();
        rst = 1'b0;
        step();
        step();
        check("idle_stays", gnt0, 8'h00);

        // single requester
        req = 8'h10;
        for (int i = 0; i < 5; i++) begin
            step();
            check("single_gnt", gnt4, 8'h10);
            check("single_idx", {5'd0, idx4}, 8'h04);
            check("single_vld", {7'd0, vld4}, 8'h01);
        end
        req = 8'h00;
        step();
        check("single_release", gnt4, 8'h00);
        check("single_release_vld", {7'd0, vld4}, 8'h00);

        // fairness: each owner drops its bit for one edge
        async_reset();
        req = 8'hFF;
        step();
        check("rr_start", {5'd0, idx0}, 8'h00);
        exp_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            req = 8'hFF & ~(8'h01 << exp_idx);
            exp_idx = exp_idx + 3'd1;
            step();
            check("rr_idx", {5'd0, idx0}, {5'd0, exp_idx});
            check("rr_onehot", gnt0, 8'h01 << exp_idx);
        end

        // back-to-back handoff
        async_reset();
        req = 8'h84;
        step();
        check("b2b_first", gnt0, 8'h04);
        check("b2b_first_idx", {5'd0, idx0}, 8'h02);
        req = 8'h80;
        step();
        check("b2b_next", gnt0, 8'h80);
        check("b2b_next_idx", {5'd0, idx0}, 8'h07);
        check("b2b_next_vld", {7'd0, vld0}, 8'h01);

        // preemption after 4 cycles; unlimited instance keeps its owner
        async_reset();
        req = 8'h03;
        for (int i = 0; i < 12; i++) begin
            step();
            check("preempt_gnt4", gnt4, ((i / 4) % 2 == 1) ? 8'h02 : 8'h01);
            check("nolimit_gnt0", gnt0, 8'h01);
        end

        // no preemption without contention, long hold past counter range
        async_reset();
        req = 8'h20;
        for (int i = 0; i < 300; i++) begin
            step();
            check("solo_hold", gnt4, 8'h20);
        end
        req = 8'h21;
        step();
        check("late_contention_gnt4", gnt4, 8'h01);
        check("late_contention_gnt0", gnt0, 8'h20);
        req = 8'h00;
        step();
        check("final_idle", gnt4, 8'h00);
        check("final_idle_vld", {7'd0, vld4}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
